// File: rtl/length_counter_multi.sv
// Multi-channel PSG length counter: per-channel load/trigger/decrement with
// registered active flags that gate each channel's sample stream.
module length_counter_multi #(
    parameter int unsigned       NUM_CH    = 4,
    parameter int unsigned       SHORT_W   = 6,
    parameter int unsigned       LONG_W    = 8,
    parameter logic [NUM_CH-1:0] LONG_MASK = 4'b0100,
    parameter int unsigned       SAMPLE_W  = 24,
    localparam int unsigned      CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         tick_256,
    input  logic                         wr_en,
    input  logic [CH_W-1:0]              wr_ch,
    input  logic                         wr_len_valid,
    input  logic [LONG_W-1:0]            wr_len,
    input  logic                         wr_len_en_valid,
    input  logic                         wr_len_en,
    input  logic                         wr_trigger,
    input  logic [NUM_CH-1:0]            dac_off,
    input  logic [NUM_CH*SAMPLE_W-1:0]   sample_in,
    output logic [NUM_CH-1:0]            active,
    output logic [NUM_CH*SAMPLE_W-1:0]   sample_out
);

    localparam int unsigned CNT_W = LONG_W + 1;

    logic [CNT_W-1:0]          cnt_q [NUM_CH];
    logic [CNT_W-1:0]          cnt_d [NUM_CH];
    logic [NUM_CH-1:0]         len_en_q, len_en_d;
    logic [NUM_CH-1:0]         active_q, active_d;
    logic [NUM_CH*SAMPLE_W-1:0] sample_q, sample_d;

    // 2^Wc for channel ch; also the value a zero length write loads.
    function automatic logic [CNT_W-1:0] full_len(int unsigned ch);
        return LONG_MASK[ch] ? (CNT_W'(1) << LONG_W) : (CNT_W'(1) << SHORT_W);
    endfunction

    always_comb begin
        len_en_d = len_en_q;
        active_d = active_q;
        sample_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            // A write to this channel masks any coincident tick for it only.
            if (wr_en && (wr_ch == CH_W'(i))) begin
                if (wr_len_valid) begin
                    cnt_d[i] = full_len(i) - (CNT_W'(wr_len) & (full_len(i) - CNT_W'(1)));
                end
                if (wr_trigger) begin
                    if (!dac_off[i]) begin
                        active_d[i] = 1'b1;
                    end
                    if (cnt_d[i] == '0) begin
                        cnt_d[i] = full_len(i);
                    end
                end
                if (wr_len_en_valid) begin
                    len_en_d[i] = wr_len_en;
                end
            end else if (tick_256 && len_en_q[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
                if (cnt_q[i] == CNT_W'(1)) begin
                    active_d[i] = 1'b0;
                end
            end
            if (dac_off[i]) begin
                active_d[i] = 1'b0;
            end
            sample_d[i*SAMPLE_W +: SAMPLE_W] =
                active_q[i] ? sample_in[i*SAMPLE_W +: SAMPLE_W] : '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            len_en_q <= '0;
            active_q <= '0;
            sample_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            len_en_q <= len_en_d;
            active_q <= active_d;
            sample_q <= sample_d;
        end
    end

    assign active     = active_q;
    assign sample_out = sample_q;

endmodule
